// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file geometry and writeback entry type.
package rf_pkg;
    localparam int RF_DEPTH = 32;
    localparam int RF_BITS  = 64;
    localparam int RF_AW    = 5;
    typedef struct packed {
        logic [RF_AW-1:0]   addr;
        logic [RF_BITS-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_match.sv
// wb_match: youngest-match lookup of one read address over the writeback queue.
module wb_match
    import rf_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int AW = RF_AW,
    parameter int BITS = RF_BITS,
    localparam int PW = $clog2(QDEPTH),
    localparam int CW = PW + 1
) (
    input  logic [PW-1:0]                i_head,
    input  logic [CW-1:0]                i_count,
    input  logic [QDEPTH-1:0][AW-1:0]    i_addrs,
    input  logic [QDEPTH-1:0][BITS-1:0]  i_datas,
    input  logic [AW-1:0]                i_qaddr,
    output logic                         o_pend,
    output logic [BITS-1:0]              o_fwd
);
    // Walk oldest to youngest so the match nearest the tail wins.
    always_comb begin
        o_pend = 1'b0;
        o_fwd  = '0;
        for (int k = 0; k < QDEPTH; k++) begin
            if (CW'(k) < i_count && i_qaddr != '0 && i_addrs[i_head + PW'(k)] == i_qaddr) begin
                o_pend = 1'b1;
                o_fwd  = i_datas[i_head + PW'(k)];
            end
        end
    end
endmodule

// File: rtl/rf_wb_sequencer.sv
// rf_wb_sequencer: merges ALU and memory writebacks into an in-order queue
// drained one entry per cycle into the register file write port.
module rf_wb_sequencer
    import rf_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    parameter int BITS = RF_BITS,
    parameter int QDEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int PW = $clog2(QDEPTH),
    localparam int CW = PW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            src0_valid,
    output logic            src0_ready,
    input  logic [AW-1:0]   src0_addr,
    input  logic [BITS-1:0] src0_data,
    input  logic            src1_valid,
    output logic            src1_ready,
    input  logic [AW-1:0]   src1_addr,
    input  logic [BITS-1:0] src1_data,
    output logic [AW-1:0]   rf_addressw,
    output logic [BITS-1:0] rf_writeData,
    output logic            rf_writeEn,
    input  logic [AW-1:0]   q_addr1,
    input  logic [AW-1:0]   q_addr2,
    output logic            pend1,
    output logic            pend2,
    output logic [BITS-1:0] fwd1,
    output logic [BITS-1:0] fwd2,
    output logic [CW-1:0]   q_count
);
    logic [PW-1:0]               r_head;
    logic [PW-1:0]               r_tail;
    logic [CW-1:0]               r_count;
    logic [QDEPTH-1:0][AW-1:0]   r_addr;
    logic [QDEPTH-1:0][BITS-1:0] r_data;
    logic                        w_en0;
    logic                        w_en1;
    logic                        w_deq;
    logic [PW-1:0]               w_slot1;
    // Readies look only at registered occupancy, never at this cycle's drain.
    assign src0_ready = r_count <= CW'(QDEPTH - 1);
    assign src1_ready = r_count <= CW'(QDEPTH - 2);
    assign w_en0      = src0_valid & src0_ready & (src0_addr != '0);
    assign w_en1      = src1_valid & src1_ready & (src1_addr != '0);
    assign w_deq      = r_count != '0;
    assign w_slot1    = r_tail + PW'(w_en0);
    assign rf_writeEn   = w_deq;
    assign rf_addressw  = w_deq ? r_addr[r_head] : '0;
    assign rf_writeData = w_deq ? r_data[r_head] : '0;
    assign q_count      = r_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_deq);
            r_tail  <= r_tail + PW'(w_en0) + PW'(w_en1);
            r_count <= r_count + CW'(w_en0) + CW'(w_en1) - CW'(w_deq);
        end
    end
    // Payload needs no reset: occupancy gates every use of it.
    always_ff @(posedge clk) begin
        if (w_en0) begin
            r_addr[r_tail] <= src0_addr;
            r_data[r_tail] <= src0_data;
        end
        if (w_en1) begin
            r_addr[w_slot1] <= src1_addr;
            r_data[w_slot1] <= src1_data;
        end
    end
    wb_match #(.QDEPTH(QDEPTH), .AW(AW), .BITS(BITS)) u_match1 (
        .i_head  (r_head),
        .i_count (r_count),
        .i_addrs (r_addr),
        .i_datas (r_data),
        .i_qaddr (q_addr1),
        .o_pend  (pend1),
        .o_fwd   (fwd1)
    );
    wb_match #(.QDEPTH(QDEPTH), .AW(AW), .BITS(BITS)) u_match2 (
        .i_head  (r_head),
        .i_count (r_count),
        .i_addrs (r_addr),
        .i_datas (r_data),
        .i_qaddr (q_addr2),
        .o_pend  (pend2),
        .o_fwd   (fwd2)
    );
endmodule

// File: tb/tb_rf_wb_sequencer.sv
// tb_rf_wb_sequencer: queue-model scoreboard plus directed literal checks.
module tb_rf_wb_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        src0_valid, src0_ready, src1_valid, src1_ready;
    logic [4:0]  src0_addr, src1_addr, rf_addressw, q_addr1, q_addr2;
    logic [63:0] src0_data, src1_data, rf_writeData, fwd1, fwd2;
    logic        rf_writeEn, pend1, pend2;
    logic [2:0]  q_count;
    int checks = 0;
    int errors = 0;
    typedef struct {logic [4:0] addr; logic [63:0] data;} ent_t;
    ent_t model[$];
    ent_t wlog[$];
    bit   logging = 0;

    rf_wb_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_addr(src0_addr), .src0_data(src0_data),
        .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_addr(src1_addr), .src1_data(src1_data),
        .rf_addressw(rf_addressw), .rf_writeData(rf_writeData), .rf_writeEn(rf_writeEn),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .pend1(pend1), .pend2(pend2),
        .fwd1(fwd1), .fwd2(fwd2), .q_count(q_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void lookup(input logic [4:0] a, output logic p, output logic [63:0] d);
        p = 0;
        d = '0;
        if (a != 0)
            for (int i = model.size() - 1; i >= 0; i--)
                if (model[i].addr == a) begin
                    p = 1;
                    d = model[i].data;
                    break;
                end
    endfunction

    always @(negedge clk) begin
        int n;
        logic p;
        logic [63:0] d;
        bit r0, r1;
        if (!rst_n) model.delete();
        n = model.size();
        r0 = n <= 3;
        r1 = n <= 2;
        chk("count", 64'(q_count), 64'(n));
        chk("ready0", 64'(src0_ready), 64'(r0));
        chk("ready1", 64'(src1_ready), 64'(r1));
        chk("wen", 64'(rf_writeEn), 64'(n > 0));
        chk("waddr", 64'(rf_addressw), n > 0 ? 64'(model[0].addr) : 64'd0);
        chk("wdata", rf_writeData, n > 0 ? model[0].data : 64'd0);
        lookup(q_addr1, p, d);
        chk("pend1", 64'(pend1), 64'(p));
        chk("fwd1", fwd1, d);
        lookup(q_addr2, p, d);
        chk("pend2", 64'(pend2), 64'(p));
        chk("fwd2", fwd2, d);
        if (logging && rf_writeEn) wlog.push_back('{rf_addressw, rf_writeData});
        if (rst_n) begin
            if (n > 0) void'(model.pop_front());
            if (src0_valid && r0 && src0_addr != 0) model.push_back('{src0_addr, src0_data});
            if (src1_valid && r1 && src1_addr != 0) model.push_back('{src1_addr, src1_data});
            chk("bound", 64'(model.size() <= 4), 64'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        src0_valid = 0;
        src1_valid = 0;
    endtask

    initial begin
        rst_n = 0;
        src0_valid = 0; src1_valid = 0;
        src0_addr = 0; src1_addr = 0; src0_data = 0; src1_data = 0;
        q_addr1 = 0; q_addr2 = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_count", 64'(q_count), 0);
        chk("rst_rdy0", 64'(src0_ready), 1);
        chk("rst_rdy1", 64'(src1_ready), 1);
        chk("rst_wen", 64'(rf_writeEn), 0);

        src0_valid = 1; src0_addr = 5; src0_data = 64'hAA;
        step(); idle();
        chk("single_wen", 64'(rf_writeEn), 1);
        chk("single_addr", 64'(rf_addressw), 5);
        chk("single_data", rf_writeData, 64'hAA);
        step();
        chk("single_done", 64'(rf_writeEn), 0);

        q_addr1 = 3;
        src0_valid = 1; src0_addr = 3; src0_data = 64'h11;
        src1_valid = 1; src1_addr = 3; src1_data = 64'h22;
        step(); idle();
        chk("dual_first", rf_writeData, 64'h11);
        chk("dual_count", 64'(q_count), 2);
        chk("dual_pend_a", 64'(pend1), 1);
        chk("dual_fwd_a", fwd1, 64'h22);
        step();
        chk("dual_second", rf_writeData, 64'h22);
        chk("dual_pend_b", 64'(pend1), 1);
        chk("dual_fwd_b", fwd1, 64'h22);
        step();
        chk("dual_done", 64'(rf_writeEn), 0);
        chk("dual_pend_c", 64'(pend1), 0);

        q_addr1 = 0;
        chk("x0_ready", 64'(src1_ready), 1);
        src1_valid = 1; src1_addr = 0; src1_data = 64'hFF;
        step(); idle();
        chk("x0_wen", 64'(rf_writeEn), 0);
        chk("x0_count", 64'(q_count), 0);
        chk("x0_pend", 64'(pend1), 0);

        q_addr2 = 7;
        for (int i = 0; i < 8; i++) begin
            src0_valid = 1; src0_addr = 5'(1 + (2 * i) % 30); src0_data = 64'(100 + i);
            src1_valid = 1; src1_addr = 5'(2 + (2 * i) % 30); src1_data = 64'(200 + i);
            step();
        end
        chk("bp_count", 64'(q_count), 3);
        chk("bp_rdy0", 64'(src0_ready), 1);
        chk("bp_rdy1", 64'(src1_ready), 0);
        idle();
        repeat (4) step();
        chk("bp_drained", 64'(q_count), 0);

        logging = 1;
        for (int i = 1; i <= 12; i++) begin
            src0_valid = 1; src0_addr = 5'(i); src0_data = 64'(i);
            step();
        end
        idle();
        repeat (3) step();
        logging = 0;
        chk("wrap_len", 64'(wlog.size()), 12);
        for (int k = 0; k < wlog.size() && k < 12; k++) begin
            chk("wrap_addr", 64'(wlog[k].addr), 64'(k + 1));
            chk("wrap_data", wlog[k].data, 64'(k + 1));
        end

        src0_valid = 1; src0_addr = 9;  src0_data = 1;
        src1_valid = 1; src1_addr = 10; src1_data = 2;
        step();
        src0_addr = 11; src0_data = 3;
        src1_addr = 12; src1_data = 4;
        step(); idle();
        chk("mid_count", 64'(q_count), 3);
        rst_n = 0;
        #2;
        chk("mid_rst_count", 64'(q_count), 0);
        chk("mid_rst_wen", 64'(rf_writeEn), 0);
        step(); step();
        rst_n = 1;
        chk("mid_rdy0", 64'(src0_ready), 1);
        chk("mid_rdy1", 64'(src1_ready), 1);
        repeat (3) step();
        chk("mid_nowrite", 64'(rf_writeEn), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_wb_sequencer.md
Name: rf_wb_sequencer

Overview:
- Sequences all writebacks into the 32x64 register file's single write port.
- Merges two writeback sources into one in-order queue: src0 is the ALU/execute result, src1 is the load/memory result.
- Drains one entry per cycle into the register file.
- Exposes pending-write lookup and forwarding for the two decode read addresses, so decode can bypass or stall.

Parameters:
- DEPTH, 32: register count; address width AW = $clog2(DEPTH).
- BITS, 64: data width.
- QDEPTH, 4: writeback queue entries (power of 2, >= 2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- src0_valid  in  1  ALU writeback valid.
- src0_ready  out  1  src0 accepted when valid & ready.
- src0_addr  in  AW  destination register.
- src0_data  in  BITS  write value.
- src1_valid  in  1  memory writeback valid.
- src1_ready  out  1  src1 accepted when valid & ready.
- src1_addr  in  AW  destination register.
- src1_data  in  BITS  write value.
- rf_addressw  out  AW  register file write address.
- rf_writeData  out  BITS  register file write data.
- rf_writeEn  out  1  register file write enable.
- q_addr1  in  AW  decode read address 1.
- q_addr2  in  AW  decode read address 2.
- pend1  out  1  queued write pending to q_addr1.
- pend2  out  1  queued write pending to q_addr2.
- fwd1  out  BITS  youngest queued data for q_addr1.
- fwd2  out  BITS  youngest queued data for q_addr2.
- q_count  out  $clog2(QDEPTH)+1  occupied entries.

Behaviour:
- Reset: rst_n low clears the queue asynchronously. head = tail = count = 0. All outputs 0 except src0_ready = src1_ready = 1. Entries held at reset are discarded, not written.
- Queue entry: {addr, data}, held in flops. Circular buffer; head/tail wrap modulo QDEPTH.
- Ready, from registered count only, never dependent on same-cycle drain:
  - src0_ready = (QDEPTH - count) >= 1.
  - src1_ready = (QDEPTH - count) >= 2.
- Accept order, same cycle: src0 enqueued before src1 (src0 is the older instruction).
- x0 writes: an accepted write with addr == 0 is consumed (handshake completes) but not enqueued.
- Drain: if count > 0, rf_writeEn = 1 and rf_addressw/rf_writeData = head entry (combinational from head flops). Head advances at the clock edge. Register file never stalls.
- Latency: write accepted at edge N drives the rf port in cycle N+1 at the earliest (empty queue); otherwise after all older entries.
- Simultaneous enqueue(s) and dequeue in one cycle: count_next = count + accepted_nonzero - (count > 0). Never overflows, given the ready rules.
- Full (count == QDEPTH): both readies 0; drain continues.
- Empty: rf_writeEn = 0; rf_addressw and rf_writeData driven 0.
- Lookup (combinational over registered entries only; same-cycle incoming writes are not visible):
  - pendN = 1 iff q_addrN != 0 and any valid entry addr == q_addrN.
  - fwdN = data of the youngest matching entry (nearest tail), else 0.
- Head-entry match: the head is being written this cycle. It still reports pending; the register file value becomes visible the next cycle.
- Same address queued twice: drained in order, so the younger value lands last; forwarding returns the younger value.

Decomposition:
- Shared package rf_pkg:
  - localparams RF_DEPTH = 32, RF_BITS = 64, RF_AW = 5.
  - typedef wb_entry_t {logic [RF_AW-1:0] addr; logic [RF_BITS-1:0] data;}.
- Sub-module wb_match: one instance per lookup port. Youngest-match priority search over queue entries, ordered from tail backwards.

Test Plan:
- Reset mid-drain: enqueue 3 entries, assert rst_n low between edges. count = 0, rf_writeEn = 0 immediately; src0_ready = src1_ready = 1 after release; no further writes.
- Single write: src0 (addr 5, data 0xAA) at edge 0. Cycle 1: rf_writeEn = 1, rf_addressw = 5, rf_writeData = 0xAA. Cycle 2: rf_writeEn = 0.
- Dual accept ordering: same edge, src0 (3, 0x11) and src1 (3, 0x22). Writes drain 0x11 then 0x22. pend1 = 1 and fwd1 = 0x22 (q_addr1 = 3) until the second write drains.
- x0 drop: src1 (addr 0, 0xFF) accepted. No rf_writeEn; q_count stays 0; pend1 = 0 with q_addr1 = 0.
- Full / backpressure:
  - Hold both sources valid with distinct addrs; readies follow the free-count rules.
  - count never exceeds 4.
  - Exactly one rf write per cycle while non-empty.
- Wrap-around: stream 12 src0 writes (addr 1..12, data = addr) at one per cycle. All 12 appear on the rf port in order with no loss after head/tail wrap.
